// File: rtl/rv32i_types.sv
// Shared RV32I branch-predictor types: the conditional-branch opcode and the
// in-flight queue entry. Entry fields are sized to the widest supported
// configuration; users take the low PHTIDX / GHR_W bits and synthesis trims
// the constant upper bits.
package rv32i_types;

  // Major opcode of all RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU)
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Largest index / history width an entry can carry (PC bits [31:2])
  localparam int BP_IDX_MAX = 30;
  localparam int BP_GHR_MAX = 30;

  // One speculatively predicted branch awaiting resolution
  typedef struct packed {
    logic [BP_IDX_MAX-1:0] idx;   // PHT index used for the prediction
    logic                  pred;  // predicted direction
    logic [BP_GHR_MAX-1:0] ghr;   // global history before this branch shifted in
  } bp_entry_t;

  // True when the opcode is a conditional branch
  function automatic logic is_cond_branch(input logic [6:0] opcode);
    return (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted-but-unresolved branches. Head entry is read
// combinationally because resolution must see it in the same cycle; the queue
// is only a handful of entries, so it lives in flops rather than block RAM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_inflight_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  bp_entry_t push_data,
  input  logic      pop,
  output bp_entry_t head_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] head_ptr;
  logic [AW:0] tail_ptr;
  logic        push_ok;
  logic        pop_ok;
  bp_entry_t   mem [DEPTH];

  assign empty   = (head_ptr == tail_ptr);
  assign full    = (head_ptr[AW] != tail_ptr[AW]) &&
                   (head_ptr[AW-1:0] == tail_ptr[AW-1:0]);
  // A flush squashes everything, so a coincident push or pop is meaningless
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign head_data = mem[head_ptr[AW-1:0]];

  // Pointer update: flush empties the queue, otherwise advance on push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  head_ptr <= head_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry storage; stale contents are harmless because pointers gate validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ghr_index_gen.sv
// Global-history (gshare-style) PHT index generator. Forms the PHT read index
// from the fetch PC and the speculative global history, queues each predicted
// branch, and on resolution issues the PHT update and repairs the history
// after a misprediction.
module ghr_index_gen
  import rv32i_types::*;
#(
  parameter int PHTIDX = 4,
  parameter int GHR_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  input  logic [6:0]        fetch_opcode,
  input  logic              pred_result,
  input  logic              resolve_valid,
  input  logic              resolve_br_en,
  output logic [PHTIDX-1:0] pht_r_idx,
  output logic [PHTIDX-1:0] pht_w_idx,
  output logic              update_pht,
  output logic              br_en,
  output logic              mis_predict,
  output logic              stall
);

  logic [GHR_W-1:0]  ghr;
  logic [GHR_W-1:0]  ghr_spec;
  logic [GHR_W-1:0]  ghr_fix;
  logic [PHTIDX-1:0] ghr_ext;
  logic [GHR_W-1:0]  head_ghr;
  logic [PHTIDX-1:0] head_idx;
  logic              fetch_branch;
  logic              pop;
  logic              mispredict;
  logic              push;
  logic              q_full;
  logic              q_empty;
  bp_entry_t         push_data;
  bp_entry_t         head_data;
  logic              unused_bits;

  // History zero-extended to index width before hashing with the PC
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr;
  end

  assign pht_r_idx = fetch_pc[PHTIDX+1:2] ^ ghr_ext;

  assign head_ghr = head_data.ghr[GHR_W-1:0];
  assign head_idx = head_data.idx[PHTIDX-1:0];

  // Resolution of an empty queue is ignored; a misprediction flushes and
  // takes priority over any branch being fetched in the same cycle. A full
  // queue blocks pushes even if a correct pop frees a slot this cycle.
  assign fetch_branch = fetch_valid && is_cond_branch(fetch_opcode);
  assign pop          = resolve_valid && !q_empty;
  assign mispredict   = pop && (head_data.pred != resolve_br_en);
  assign push         = fetch_branch && !q_full && !mispredict;
  assign stall        = q_full;

  // Queue entry: index and history as seen at prediction time
  always_comb begin
    push_data = '0;
    push_data.idx[PHTIDX-1:0] = pht_r_idx;
    push_data.pred            = pred_result;
    push_data.ghr[GHR_W-1:0]  = ghr;
  end

  // Speculative shift and post-mispredict repair of the history
  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_spec = pred_result;
      assign ghr_fix  = resolve_br_en;
    end else begin : g_ghrn
      assign ghr_spec = {ghr[GHR_W-2:0], pred_result};
      assign ghr_fix  = {head_ghr[GHR_W-2:0], resolve_br_en};
    end
  endgenerate

  // Global history register: repair on mispredict, else shift on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (mispredict) begin
      ghr <= ghr_fix;
    end else if (push) begin
      ghr <= ghr_spec;
    end
  end

  // Registered PHT update interface, one-cycle pulses after each pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht_w_idx   <= '0;
      update_pht  <= 1'b0;
      br_en       <= 1'b0;
      mis_predict <= 1'b0;
    end else begin
      update_pht  <= pop;
      br_en       <= pop && resolve_br_en;
      mis_predict <= mispredict;
      if (pop) pht_w_idx <= head_idx;
    end
  end

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (mispredict),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (q_full),
    .empty     (q_empty)
  );

  // PC bits outside the index and entry bits above the configured widths
  assign unused_bits = ^{fetch_pc, head_data};

endmodule
